// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and width definitions for the ALU responder.
// Also holds the single-cycle evaluation of every non-multiply opcode.
package alu_pkg;

    localparam int ALU_DW   = 8;
    localparam int ALU_SELW = 4;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_SUB    = 4'd1;
    localparam logic [3:0] OP_MUL    = 4'd2;
    localparam logic [3:0] OP_AND    = 4'd3;
    localparam logic [3:0] OP_OR     = 4'd4;
    localparam logic [3:0] OP_NOT    = 4'd5;
    localparam logic [3:0] OP_XOR    = 4'd6;
    localparam logic [3:0] OP_XNOR   = 4'd7;
    localparam logic [3:0] OP_LSHIFT = 4'd8;
    localparam logic [3:0] OP_RSHIFT = 4'd9;
    localparam logic [3:0] OP_L_AND  = 4'd10;
    localparam logic [3:0] OP_L_OR   = 4'd11;
    localparam logic [3:0] OP_L_NOT  = 4'd12;
    localparam logic [3:0] OP_EQ     = 4'd13;
    localparam logic [3:0] OP_GT     = 4'd14;
    localparam logic [3:0] OP_LT     = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Operands are zero-extended; everything is unsigned.
    function automatic logic [15:0] alu_eval(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [3:0] sel
    );
        logic [15:0] a16;
        logic [15:0] b16;
        logic [15:0] y;
        a16 = {8'h00, a};
        b16 = {8'h00, b};
        y   = 16'h0000;
        case (sel)
            OP_ADD:    y = a16 + b16;
            OP_SUB:    y = a16 - b16;
            OP_AND:    y = {8'h00, a & b};
            OP_OR:     y = {8'h00, a | b};
            OP_NOT:    y = {8'h00, ~a};
            OP_XOR:    y = {8'h00, a ^ b};
            OP_XNOR:   y = {8'h00, ~(a ^ b)};
            OP_LSHIFT: y = (b >= 8'd16) ? 16'h0000 : (a16 << b[3:0]);
            OP_RSHIFT: y = (b >= 8'd16) ? 16'h0000 : (a16 >> b[3:0]);
            OP_L_AND:  y = {15'd0, (a != 8'd0) && (b != 8'd0)};
            OP_L_OR:   y = {15'd0, (a != 8'd0) || (b != 8'd0)};
            OP_L_NOT:  y = {15'd0, a == 8'd0};
            OP_EQ:     y = {15'd0, a == b};
            OP_GT:     y = {15'd0, a > b};
            OP_LT:     y = {15'd0, a < b};
            default:   y = 16'h0000;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add 8x8->16 unsigned multiplier, one partial product per cycle.
// done_o is high during the 8th iteration; prod_o then carries the final product.
module alu_seq_mul
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        done_o,
    output logic [15:0] prod_o
);

    logic [15:0] acc_q;
    logic [15:0] mcand_q;
    logic [7:0]  mplier_q;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic [15:0] acc_d;

    assign acc_d  = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);
    assign done_o = busy_q && (cnt_q == 3'd7);
    assign prod_o = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= 16'h0000;
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b0;
        end else if (start_i) begin
            acc_q    <= 16'h0000;
            mcand_q  <= {8'h00, a_i};
            mplier_q <= b_i;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_op_responder.sv
// Handshaked ALU endpoint: one request in flight, registered result held
// until the consumer takes it. MUL goes through the iterative engine.
module alu_op_responder
    import alu_pkg::*;
#(
    parameter int DW   = ALU_DW,
    parameter int SELW = ALU_SELW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [DW-1:0]   req_a,
    input  logic [DW-1:0]   req_b,
    input  logic [SELW-1:0] req_sel,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [2*DW-1:0] rsp_y,
    output logic [SELW-1:0] rsp_sel
);

    state_t          state_q;
    logic [2*DW-1:0] y_q;
    logic [SELW-1:0] sel_q;
    logic            accept;
    logic            mul_start;
    logic            mul_done;
    logic [15:0]     mul_prod;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign mul_start = accept && (req_sel == OP_MUL);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_y     = y_q;
    assign rsp_sel   = sel_q;

    alu_seq_mul u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start),
        .a_i     (req_a),
        .b_i     (req_b),
        .done_o  (mul_done),
        .prod_o  (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            y_q     <= '0;
            sel_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        sel_q <= req_sel;
                        if (req_sel == OP_MUL) begin
                            state_q <= S_MUL;
                        end else begin
                            y_q     <= alu_eval(req_a, req_b, req_sel);
                            state_q <= S_RESP;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        y_q     <= mul_prod;
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
